dram_controller: RTL and testbench

Sequences page-mode-free DRAM accesses for the 68000 RAM region and interleaves CAS-before-RAS refresh. Sits behind the address decoder: consumes its active-low RAM chip-select plus the raw CPU strobes and drives RAS/CAS/WE, the row/column address-mux select, and the RAM-side DTACK. Owns all arbitration between CPU accesses and refresh.

---
 rtl/dram_controller_pkg.sv | 24 ++
 rtl/dram_controller_if.sv | 26 ++
 rtl/dram_refresh_timer.sv | 36 +++
 rtl/dram_controller.sv | 162 ++++++++++++++++
 tb/tb_dram_controller.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/dram_controller_pkg.sv
// Shared types and defaults for the DRAM controller: FSM state encoding,
// default timing constants and a counter-width helper.
package dram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        CAS,
        PRECHARGE,
        REF_CAS,
        REF_RAS
    } dram_state_e;

    localparam int DEF_REFRESH_PERIOD   = 234;
    localparam int DEF_PRECHARGE_CYCLES = 2;
    localparam int DEF_REF_RAS_CYCLES   = 2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_controller_if.sv
// CPU strobes in, DRAM strobes and RAM-side DTACK out. Active-low signals
// keep their board names.
interface dram_controller_if;
    logic AS;
    logic UDS;
    logic LDS;
    logic RW;
    logic RAMEN;
    logic RAS;
    logic CASU;
    logic CASL;
    logic WE;
    logic ADDR_SEL;
    logic DTACK;
    logic REF_BUSY;

    modport master (
        output AS, UDS, LDS, RW, RAMEN,
        input  RAS, CASU, CASL, WE, ADDR_SEL, DTACK, REF_BUSY
    );

    modport slave (
        input  AS, UDS, LDS, RW, RAMEN,
        output RAS, CASU, CASL, WE, ADDR_SEL, DTACK, REF_BUSY
    );
endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises a single (non-queued)
// pending request on every wrap until the FSM acknowledges it.
module dram_refresh_timer
    import dram_ctrl_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
    input  logic CLK,
    input  logic RST,
    input  logic ack_i,
    output logic pending_o
);
    localparam int CW = cnt_width(REFRESH_PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          wrap;

    always_comb begin
        wrap      = (cnt_q == CW'(REFRESH_PERIOD - 1));
        cnt_d     = wrap ? '0 : cnt_q + CW'(1);
        pending_d = wrap | (pending_q & ~ack_i);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/dram_controller.sv
// DRAM sequencer for the 68000 RAM region: RAS/CAS access cycles with
// interleaved CAS-before-RAS refresh. All outputs are registered.
module dram_controller
    import dram_ctrl_pkg::*;
#(
    parameter int REFRESH_PERIOD   = DEF_REFRESH_PERIOD,
    parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES,
    parameter int REF_RAS_CYCLES   = DEF_REF_RAS_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    dram_controller_if.slave  bus
);
    localparam int HOLD_MAX = (PRECHARGE_CYCLES > REF_RAS_CYCLES) ? PRECHARGE_CYCLES
                                                                  : REF_RAS_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    dram_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rw_q, rw_d;
    logic              ras_q, ras_d;
    logic              casu_q, casu_d;
    logic              casl_q, casl_d;
    logic              we_q, we_d;
    logic              asel_q, asel_d;
    logic              dtack_q, dtack_d;
    logic              refb_q, refb_d;
    logic              pending;
    logic              ref_ack;

    dram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .CLK       (CLK),
        .RST       (RST),
        .ack_i     (ref_ack),
        .pending_o (pending)
    );

    // The last precharge cycle doubles as IDLE so a waiting CPU cycle starts
    // without an extra dead cycle after refresh.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rw_d    = rw_q;
        case (state_q)
            IDLE, PRECHARGE: begin
                if (state_q == PRECHARGE && hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (pending) begin
                    state_d = REF_CAS;
                end else if (!bus.AS && !bus.RAMEN) begin
                    state_d = ROW;
                    rw_d    = bus.RW;
                end else begin
                    state_d = IDLE;
                end
            end
            ROW:     state_d = bus.AS ? PRECHARGE : COL;
            COL:     state_d = bus.AS ? PRECHARGE : CAS;
            CAS: begin
                if (bus.AS) begin
                    state_d = PRECHARGE;
                end
            end
            REF_CAS: state_d = REF_RAS;
            REF_RAS: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    state_d = PRECHARGE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == PRECHARGE && state_q != PRECHARGE) begin
            hold_d = HOLD_W'(PRECHARGE_CYCLES - 1);
        end
        if (state_d == REF_RAS && state_q != REF_RAS) begin
            hold_d = HOLD_W'(REF_RAS_CYCLES - 1);
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge the state does.
    always_comb begin
        ras_d   = 1'b1;
        casu_d  = 1'b1;
        casl_d  = 1'b1;
        we_d    = 1'b1;
        asel_d  = 1'b0;
        dtack_d = 1'b1;
        refb_d  = 1'b0;
        ref_ack = (state_d == REF_CAS);
        case (state_d)
            ROW: begin
                ras_d = 1'b0;
                we_d  = rw_d;
            end
            COL: begin
                ras_d  = 1'b0;
                asel_d = 1'b1;
                we_d   = rw_d;
            end
            CAS: begin
                ras_d   = 1'b0;
                asel_d  = 1'b1;
                we_d    = rw_d;
                casu_d  = bus.UDS;
                casl_d  = bus.LDS;
                dtack_d = dtack_q & bus.UDS & bus.LDS;
            end
            REF_CAS: begin
                casu_d = 1'b0;
                casl_d = 1'b0;
                refb_d = 1'b1;
            end
            REF_RAS: begin
                ras_d  = 1'b0;
                casu_d = 1'b0;
                casl_d = 1'b0;
                refb_d = 1'b1;
            end
            PRECHARGE: refb_d = refb_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rw_q    <= 1'b1;
            ras_q   <= 1'b1;
            casu_q  <= 1'b1;
            casl_q  <= 1'b1;
            we_q    <= 1'b1;
            asel_q  <= 1'b0;
            dtack_q <= 1'b1;
            refb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rw_q    <= rw_d;
            ras_q   <= ras_d;
            casu_q  <= casu_d;
            casl_q  <= casl_d;
            we_q    <= we_d;
            asel_q  <= asel_d;
            dtack_q <= dtack_d;
            refb_q  <= refb_d;
        end
    end

    assign bus.RAS      = ras_q;
    assign bus.CASU     = casu_q;
    assign bus.CASL     = casl_q;
    assign bus.WE       = we_q;
    assign bus.ADDR_SEL = asel_q;
    assign bus.DTACK    = dtack_q;
    assign bus.REF_BUSY = refb_q;
endmodule

// File: tb/tb_dram_controller.sv
// Directed bench for dram_controller: a default-period instance for CPU
// cycles and a REFRESH_PERIOD=8 instance for refresh and collision timing.
module tb_dram_controller;
    import dram_ctrl_pkg::*;

    // Input vector packing: {AS, UDS, LDS, RW, RAMEN}
    localparam logic [4:0] IN_IDLE  = 5'b11111;
    localparam logic [4:0] IN_RD    = 5'b00010;
    localparam logic [4:0] IN_RD_NS = 5'b01110;
    localparam logic [4:0] IN_WR_NS = 5'b01100;
    localparam logic [4:0] IN_WR_L  = 5'b01000;
    localparam logic [4:0] IN_OTHER = 5'b01111;

    // Output packing: {RAS, CASU, CASL, WE, ADDR_SEL, DTACK, REF_BUSY}
    localparam logic [6:0] O_IDLE   = 7'b1111010;
    localparam logic [6:0] O_ROW_RD = 7'b0111010;
    localparam logic [6:0] O_COL_RD = 7'b0111110;
    localparam logic [6:0] O_CAS_RD = 7'b0001100;
    localparam logic [6:0] O_ROW_WR = 7'b0110010;
    localparam logic [6:0] O_COL_WR = 7'b0110110;
    localparam logic [6:0] O_CAS_WL = 7'b0100100;
    localparam logic [6:0] O_REF_C  = 7'b1001011;
    localparam logic [6:0] O_REF_R  = 7'b0001011;
    localparam logic [6:0] O_REF_P  = 7'b1111011;

    typedef struct {
        string      name;
        logic [4:0] in;
        logic [6:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic rst_a;
    logic rst_r;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    dram_controller_if bus_a ();
    dram_controller_if bus_r ();

    dram_controller dut_a (
        .CLK (CLK),
        .RST (rst_a),
        .bus (bus_a)
    );

    dram_controller #(
        .REFRESH_PERIOD   (8),
        .PRECHARGE_CYCLES (2),
        .REF_RAS_CYCLES   (2)
    ) dut_r (
        .CLK (CLK),
        .RST (rst_r),
        .bus (bus_r)
    );

    wire [6:0] obs_a = {bus_a.RAS, bus_a.CASU, bus_a.CASL, bus_a.WE,
                        bus_a.ADDR_SEL, bus_a.DTACK, bus_a.REF_BUSY};
    wire [6:0] obs_r = {bus_r.RAS, bus_r.CASU, bus_r.CASL, bus_r.WE,
                        bus_r.ADDR_SEL, bus_r.DTACK, bus_r.REF_BUSY};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_a(input logic [4:0] v);
        {bus_a.AS, bus_a.UDS, bus_a.LDS, bus_a.RW, bus_a.RAMEN} = v;
    endtask

    task automatic drive_r(input logic [4:0] v);
        {bus_r.AS, bus_r.UDS, bus_r.LDS, bus_r.RW, bus_r.RAMEN} = v;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (RAS CASU CASL WE ASEL DTACK RBUSY)",
                     name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [4:0] in, input logic [6:0] exp);
        vec_t v;
        v.name = name;
        v.in   = in;
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    // Idle-bus refresh pattern, s = edges after reset release, period 8.
    function automatic logic [6:0] ref_exp(input int s);
        int ph;
        if (s < 9) return O_IDLE;
        ph = (s - 9) % 8;
        case (ph)
            0:       return O_REF_C;
            1, 2:    return O_REF_R;
            3, 4:    return O_REF_P;
            default: return O_IDLE;
        endcase
    endfunction

    initial begin
        logic [6:0] coll [8];

        rst_a = 1'b0;
        rst_r = 1'b0;
        drive_a(IN_IDLE);
        drive_r(IN_IDLE);
        step();
        step();
        check("reset_a", obs_a, O_IDLE);
        check("reset_r", obs_r, O_IDLE);
        rst_a = 1'b1;
        rst_r = 1'b1;

        add("rd_row",   IN_RD,    O_ROW_RD);
        add("rd_col",   IN_RD,    O_COL_RD);
        add("rd_cas0",  IN_RD,    O_CAS_RD);
        add("rd_cas1",  IN_RD,    O_CAS_RD);
        add("rd_cas2",  IN_RD,    O_CAS_RD);
        add("rd_cas3",  IN_RD,    O_CAS_RD);
        add("rd_rel",   IN_IDLE,  O_IDLE);
        add("rd_pre",   IN_IDLE,  O_IDLE);
        add("b2b_row",  IN_RD_NS, O_ROW_RD);
        add("b2b_abrt", IN_IDLE,  O_IDLE);
        add("b2b_pre",  IN_IDLE,  O_IDLE);
        add("b2b_idle", IN_IDLE,  O_IDLE);
        add("wr_row",   IN_WR_NS, O_ROW_WR);
        add("wr_col",   IN_WR_NS, O_COL_WR);
        add("wr_wait",  IN_WR_NS, O_COL_WR);
        add("wr_casl0", IN_WR_L,  O_CAS_WL);
        add("wr_casl1", IN_WR_L,  O_CAS_WL);
        add("wr_rel",   IN_IDLE,  O_IDLE);
        add("wr_pre",   IN_IDLE,  O_IDLE);
        add("wr_idle",  IN_IDLE,  O_IDLE);
        add("ab_row",   IN_RD_NS, O_ROW_RD);
        add("ab_col",   IN_RD_NS, O_COL_RD);
        add("ab_abrt",  IN_IDLE,  O_IDLE);
        add("ab_pre",   IN_IDLE,  O_IDLE);
        add("ab_idle",  IN_IDLE,  O_IDLE);
        add("oth_0",    IN_OTHER, O_IDLE);
        add("oth_1",    IN_OTHER, O_IDLE);
        add("oth_2",    IN_OTHER, O_IDLE);
        add("oth_end",  IN_IDLE,  O_IDLE);

        for (int i = 0; i < tbl.size(); i++) begin
            drive_a(tbl[i].in);
            step();
            check(tbl[i].name, obs_a, tbl[i].exp);
        end

        // Reset held three edges in the middle of a ROW cycle.
        drive_a(IN_RD);
        step();
        check("rst_pre_row", obs_a, O_ROW_RD);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_hold%0d", i), obs_a, O_IDLE);
        end
        drive_a(IN_IDLE);
        rst_a = 1'b1;
        step();
        check("rst_release", obs_a, O_IDLE);

        // Idle-bus refresh cadence, also restarting from a running refresh.
        rst_r = 1'b0;
        step();
        rst_r = 1'b1;
        for (int s = 1; s <= 25; s++) begin
            step();
            check($sformatf("refresh_s%0d", s), obs_r, ref_exp(s));
        end

        // Refresh pending and CPU request sampled on the same edge.
        coll[0] = O_REF_C;
        coll[1] = O_REF_R;
        coll[2] = O_REF_R;
        coll[3] = O_REF_P;
        coll[4] = O_REF_P;
        coll[5] = O_ROW_RD;
        coll[6] = O_COL_RD;
        coll[7] = O_CAS_RD;
        rst_r = 1'b0;
        step();
        rst_r = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
        end
        drive_r(IN_RD);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("collide_k%0d", k + 1), obs_r, coll[k]);
        end
        drive_r(IN_IDLE);
        step();
        check("collide_rel", obs_r & 7'b1111110, O_IDLE & 7'b1111110);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
